carry_bypass_subtractor_seq: RTL

- Multi-cycle signed/unsigned subtractor; the inverse-operation counterpart of the team's 32-bit carry-bypass adder.
- Computes diff = a - b - bin one BLOCK-bit slice per clock using carry-bypass block logic, rippling the carry between cycles.
- Exposes borrow, signed overflow, zero and signed-less-than flags.
- Sits behind valid/ready handshakes on both sides so an ALU sequencer can share it.

---
 rtl/carry_bypass_subtractor_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/carry_bypass_subtractor_seq.sv
// Sequential subtractor: diff = a - b - bin, one BLOCK-bit carry-bypass slice per clock,
// with borrow/overflow/zero/less-than flags behind valid/ready handshakes.
module carry_bypass_subtractor_seq #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [WIDTH-1:0]                       a,
  input  logic [WIDTH-1:0]                       b,
  input  logic                                   bin,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WIDTH-1:0]                       diff,
  output logic                                   bout,
  output logic                                   overflow,
  output logic                                   zero,
  output logic                                   lt,
  output logic [$clog2(WIDTH/BLOCK+1)-1:0]       bypass_cnt
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry;
  logic [KW-1:0]     k;

  logic [BLOCK-1:0]  a_blk;
  logic [BLOCK-1:0]  nb_blk;
  logic [BLOCK-1:0]  p;
  logic [BLOCK-1:0]  g;
  logic [BLOCK-1:0]  s;
  logic              chain;
  logic              blk_bypass;
  logic              blk_cout;
  logic [WIDTH-1:0]  diff_next;
  logic              ov_next;

  // Subtraction as a + ~b + ~bin; a block whose bits all propagate forwards its carry-in directly.
  always_comb begin
    a_blk  = a_r[BLOCK*int'(k) +: BLOCK];
    nb_blk = ~b_r[BLOCK*int'(k) +: BLOCK];
    p      = a_blk ^ nb_blk;
    g      = a_blk & nb_blk;
    s      = '0;
    chain  = carry;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      s[i]  = p[i] ^ chain;
      chain = g[i] | (p[i] & chain);
    end
    blk_bypass = &p;
    blk_cout   = blk_bypass ? carry : chain;
    diff_next  = diff;
    diff_next[BLOCK*int'(k) +: BLOCK] = s;
    ov_next    = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_next[WIDTH-1] != a_r[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      carry      <= 1'b0;
      k          <= '0;
      diff       <= '0;
      bout       <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      lt         <= 1'b0;
      bypass_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            carry      <= ~bin;
            k          <= '0;
            bypass_cnt <= '0;
            in_ready   <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          diff  <= diff_next;
          carry <= blk_cout;
          if (blk_bypass) bypass_cnt <= bypass_cnt + 1'b1;
          if (k == KW'(NBLK - 1)) begin
            bout      <= ~blk_cout;
            overflow  <= ov_next;
            zero      <= (diff_next == '0);
            lt        <= diff_next[WIDTH-1] ^ ov_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
